// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types, parity encodings and helpers
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - push/pop bundle between the receive FSM and its FIFO
interface uart_rx_fifo_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
);
    logic                     push_valid;
    logic [WIDTH-1:0]         push_data;
    logic                     pop_req;
    logic                     pop_valid;
    logic [WIDTH-1:0]         pop_data;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output push_valid, push_data, pop_req,
        input  pop_valid, pop_data, empty, full, count
    );

    modport slave (
        input  push_valid, push_data, pop_req,
        output pop_valid, pop_data, empty, full, count
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read port
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] pop_data_q;
    logic             pop_valid_q;
    logic             do_pop;
    logic             do_push;

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it.
    assign do_pop  = bus.pop_req && (count_q != '0);
    assign do_push = bus.push_valid && ((count_q != FULL_CNT) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            pop_valid_q <= do_pop;
            if (do_pop) begin
                pop_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q   <= rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= bus.push_data;
        end
    end

    assign bus.pop_data  = pop_data_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = (count_q == FULL_CNT);
    assign bus.count     = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver feeding a status-tagged receive FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          sample_tick,
    input  logic                          rx_data_in,
    input  logic                          rx_en,
    input  logic                          rx_req,
    output logic [DATA_BITS-1:0]          rx_data_out,
    output logic                          rx_valid,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    input  logic                          err_clr
);
    localparam int MID     = OVERSAMPLE / 2;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int ENTRY_W = DATA_BITS + 2;

    localparam logic [TW-1:0] TICK_S0   = TW'(MID - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(MID);
    localparam logic [TW-1:0] TICK_DEC  = TW'(MID + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    logic                 line;
    rx_state_e            state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           samp_q;
    logic                 par_q;
    logic                 perr_q;
    logic                 bit_val;
    logic                 stop_bit;
    logic                 dec_tick;
    logic                 drop;
    logic                 overrun_q;
    logic                 overrun_d;

    uart_rx_fifo_if #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) fifo_bus ();

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_data_in};
        end
    end
    assign line = sync_q[1];

    assign bit_val  = maj3(samp_q[0], samp_q[1], samp_q[2]);
    // The stop bit is judged on its third sample, so the line is used directly here.
    assign stop_bit = maj3(samp_q[0], samp_q[1], line);
    assign dec_tick = sample_tick && (state_q == ST_STOP) && (tick_q == TICK_DEC);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            samp_q    <= '0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else if (sample_tick) begin
            tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
            if (tick_q == TICK_S0)  samp_q[0] <= line;
            if (tick_q == TICK_MID) samp_q[1] <= line;
            if (tick_q == TICK_DEC) samp_q[2] <= line;
            case (state_q)
                ST_IDLE: begin
                    tick_q <= '0;
                    if (rx_en && !line) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_MID && line) begin
                        state_q <= ST_IDLE;
                    end else if (tick_q == TICK_LAST) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                        par_q     <= 1'b0;
                        perr_q    <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                        par_q   <= par_q ^ bit_val;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        perr_q  <= (PARITY == PARITY_ODD) ? ~(par_q ^ bit_val) : (par_q ^ bit_val);
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick_q == TICK_DEC) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_bus.push_valid = dec_tick;
    assign fifo_bus.push_data  = {~stop_bit, perr_q, shift_q};
    assign fifo_bus.pop_req    = rx_req;

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (sys_clk),
        .rst_i (rst),
        .bus   (fifo_bus.slave)
    );

    assign drop = dec_tick && fifo_bus.full && !(rx_req && !fifo_bus.empty);

    always_comb begin
        overrun_d = overrun_q;
        if (err_clr) overrun_d = 1'b0;
        if (drop)    overrun_d = 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign rx_data_out = fifo_bus.pop_data[DATA_BITS-1:0];
    assign rx_perr     = fifo_bus.pop_data[DATA_BITS];
    assign rx_ferr     = fifo_bus.pop_data[DATA_BITS+1];
    assign rx_valid    = fifo_bus.pop_valid;
    assign rx_empty    = fifo_bus.empty;
    assign rx_full     = fifo_bus.full;
    assign rx_count    = fifo_bus.count;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - bench for uart_rx_fifo: no-parity and even-parity receivers vs a queue model
module tb_uart_rx_fifo;
    localparam int OV    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tick, rx_en, err_clr;
    logic       line  [2];
    logic       req   [2];
    logic [7:0] dout  [2];
    logic       valid [2];
    logic       perr  [2];
    logic       ferr  [2];
    logic       empty [2];
    logic       full  [2];
    logic       ovr   [2];
    logic [2:0] cnt   [2];

    int vectors = 0;
    int errors  = 0;

    logic [9:0] mq [2][DEPTH];
    int         mh [2];
    int         ms [2];
    bit         ovr_m [2];
    logic [7:0] last_data [2];

    logic       cap_valid, cap_perr, cap_ferr;
    logic [7:0] cap_data;

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(OV), .PARITY(0), .FIFO_DEPTH(DEPTH)) u_dut (
        .sys_clk(clk), .rst(rst), .sample_tick(tick), .rx_data_in(line[0]), .rx_en(rx_en),
        .rx_req(req[0]), .rx_data_out(dout[0]), .rx_valid(valid[0]), .rx_perr(perr[0]),
        .rx_ferr(ferr[0]), .rx_empty(empty[0]), .rx_full(full[0]), .rx_count(cnt[0]),
        .overrun(ovr[0]), .err_clr(err_clr)
    );

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(OV), .PARITY(1), .FIFO_DEPTH(DEPTH)) u_dut_par (
        .sys_clk(clk), .rst(rst), .sample_tick(tick), .rx_data_in(line[1]), .rx_en(rx_en),
        .rx_req(req[1]), .rx_data_out(dout[1]), .rx_valid(valid[1]), .rx_perr(perr[1]),
        .rx_ferr(ferr[1]), .rx_empty(empty[1]), .rx_full(full[1]), .rx_count(cnt[1]),
        .overrun(ovr[1]), .err_clr(err_clr)
    );

    function automatic void m_clear();
        for (int s = 0; s < 2; s++) begin
            mh[s] = 0; ms[s] = 0; ovr_m[s] = 1'b0; last_data[s] = 8'h00;
        end
    endfunction

    function automatic void m_push(input int s, input logic [9:0] e);
        if (ms[s] < DEPTH) begin
            mq[s][(mh[s] + ms[s]) % DEPTH] = e;
            ms[s] = ms[s] + 1;
        end else begin
            ovr_m[s] = 1'b1;
        end
    endfunction

    function automatic logic [9:0] m_pop(input int s);
        logic [9:0] e;
        e = mq[s][mh[s]];
        mh[s] = (mh[s] + 1) % DEPTH;
        ms[s] = ms[s] - 1;
        return e;
    endfunction

    task automatic tick_once(input int pop_sel, input bit clr);
        tick = 1'b1;
        err_clr = clr;
        if (pop_sel >= 0) req[pop_sel] = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        err_clr = 1'b0;
        if (pop_sel >= 0) begin
            req[pop_sel] = 1'b0;
            cap_valid = valid[pop_sel];
            cap_data  = dout[pop_sel];
            cap_perr  = perr[pop_sel];
            cap_ferr  = ferr[pop_sel];
        end
        @(posedge clk); #1;
    endtask

    // en_mode: 0 enabled, 1 disabled after the start bit, 2 disabled for the whole frame
    task automatic send_frame(input int sel, input logic [7:0] data, input bit bad_par,
                              input bit bad_stop, input bit pop_dec, input bit clr_dec,
                              input int en_mode);
        logic [11:0] bits;
        logic [9:0]  popped;
        bit          did_pop;
        int          n;
        bits = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = data[i];
            n++;
        end
        if (sel == 1) begin
            bits[n] = (^data) ^ bad_par;
            n++;
        end
        bits[n] = ~bad_stop;
        n++;
        if (en_mode == 2) rx_en = 1'b0;
        for (int b = 0; b < n; b++) begin
            line[sel] = bits[b];
            if (en_mode == 1 && b == 1) rx_en = 1'b0;
            for (int t = 0; t < OV; t++) begin
                if (b == n - 1 && t == OV / 2 + 3) tick_once(pop_dec ? sel : -1, clr_dec);
                else tick_once(-1, 1'b0);
            end
        end
        did_pop = 1'b0;
        popped = '0;
        if (pop_dec && ms[sel] > 0) begin
            popped = m_pop(sel);
            did_pop = 1'b1;
        end
        if (clr_dec) begin
            ovr_m[0] = 1'b0;
            ovr_m[1] = 1'b0;
        end
        if (en_mode != 2) m_push(sel, {bad_stop, (sel == 1) && bad_par, data});
        if (pop_dec) begin
            vectors++;
            if (did_pop && (cap_valid !== 1'b1 || {cap_ferr, cap_perr, cap_data} !== popped)) begin
                errors++;
                $display("FAIL pop_at_stop: got v=%b f=%b p=%b d=%h, want v=1 f=%b p=%b d=%h",
                         cap_valid, cap_ferr, cap_perr, cap_data, popped[9], popped[8], popped[7:0]);
            end else if (!did_pop && cap_valid !== 1'b0) begin
                errors++;
                $display("FAIL pop_at_stop_empty: got v=%b, want v=0", cap_valid);
            end
            if (did_pop) last_data[sel] = popped[7:0];
        end
        line[sel] = 1'b1;
        for (int t = 0; t < 2 * OV; t++) tick_once(-1, 1'b0);
        rx_en = 1'b1;
    endtask

    task automatic pop_check(input int sel, input string name);
        logic [9:0] exp;
        bit         has;
        has = ms[sel] > 0;
        exp = '0;
        if (has) exp = m_pop(sel);
        req[sel] = 1'b1;
        @(posedge clk); #1;
        req[sel] = 1'b0;
        vectors++;
        if (has) begin
            if (valid[sel] !== 1'b1 || {ferr[sel], perr[sel], dout[sel]} !== exp) begin
                errors++;
                $display("FAIL %s: got v=%b f=%b p=%b d=%h, want v=1 f=%b p=%b d=%h", name,
                         valid[sel], ferr[sel], perr[sel], dout[sel], exp[9], exp[8], exp[7:0]);
            end
            last_data[sel] = exp[7:0];
        end else if (valid[sel] !== 1'b0 || dout[sel] !== last_data[sel]) begin
            errors++;
            $display("FAIL %s_empty: got v=%b d=%h, want v=0 d=%h", name, valid[sel], dout[sel], last_data[sel]);
        end
        @(posedge clk); #1;
        vectors++;
        if (valid[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: got rx_valid=%b, want 0", name, valid[sel]);
        end
    endtask

    task automatic check_status(input int sel, input string name);
        logic [5:0] got, want;
        got  = {cnt[sel], empty[sel], full[sel], ovr[sel]};
        want = {3'(ms[sel]), ms[sel] == 0, ms[sel] == DEPTH, ovr_m[sel]};
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got cnt/empty/full/ovr=%b, want %b", name, got, want);
        end
    endtask

    task automatic check_reset_vals(input string name);
        logic [15:0] want;
        want = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if ({dout[s], valid[s], perr[s], ferr[s], empty[s], full[s], cnt[s], ovr[s]} !== want) begin
                errors++;
                $display("FAIL %s[%0d]: got %h, want %h", name, s,
                         {dout[s], valid[s], perr[s], ferr[s], empty[s], full[s], cnt[s], ovr[s]}, want);
            end
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        ovr_m[0] = 1'b0;
        ovr_m[1] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        check_reset_vals("reset");
    endtask

    task automatic test_basic();
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_status(0, "basic_count");
        pop_check(0, "basic_pop");
        pop_check(0, "pop_when_empty");
    endtask

    task automatic test_parity();
        send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        send_frame(1, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_status(1, "parity_count");
        pop_check(1, "parity_err_pop");
        pop_check(1, "parity_ok_pop");
    endtask

    task automatic test_framing();
        send_frame(0, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        send_frame(0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_status(0, "framing_count");
        pop_check(0, "framing_err_pop");
        pop_check(0, "framing_next_pop");
    endtask

    task automatic test_glitch();
        line[0] = 1'b0;
        tick_once(-1, 1'b0);
        tick_once(-1, 1'b0);
        line[0] = 1'b1;
        for (int t = 0; t < 3 * OV; t++) tick_once(-1, 1'b0);
        check_status(0, "glitch_count");
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pop_check(0, "after_glitch_pop");
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_status(0, "overrun_set");
        send_frame(0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check_status(0, "overrun_clr_collide");
        for (int i = 0; i < 4; i++) pop_check(0, "overrun_pop");
        check_status(0, "overrun_drained");
        pulse_clr();
        check_status(0, "overrun_cleared");
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 4; i++) send_frame(0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_frame(0, 8'hC7, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        check_status(0, "push_pop_full");
        for (int i = 0; i < 4; i++) pop_check(0, "push_pop_drain");
    endtask

    task automatic test_rx_en();
        send_frame(0, 8'h9A, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        check_status(0, "rx_en_blocked");
        send_frame(0, 8'h6B, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        check_status(0, "rx_en_midframe");
        pop_check(0, "rx_en_midframe_pop");
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 36; i++) begin
            sel = int'($urandom_range(0, 1));
            send_frame(sel, 8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) == 0, 1'b0, 0);
            check_status(sel, "rand_status");
            if ($urandom_range(0, 2) == 0) pop_check(sel, "rand_pop");
            if ($urandom_range(0, 9) == 0) pulse_clr();
        end
        for (int s = 0; s < 2; s++) begin
            while (ms[s] > 0) pop_check(s, "rand_drain");
            check_status(s, "rand_final");
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(0, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_frame(0, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int t = 0; t < 20; t++) begin
            line[0] = (t >= 8 && t < 16);
            tick_once(-1, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        line[0] = 1'b1;
        m_clear();
        check_reset_vals("reset_mid_frame");
        for (int t = 0; t < 2 * OV; t++) tick_once(-1, 1'b0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_status(0, "after_reset_count");
        pop_check(0, "after_reset_pop");
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        rx_en = 1'b1;
        err_clr = 1'b0;
        line[0] = 1'b1;
        line[1] = 1'b1;
        req[0] = 1'b0;
        req[1] = 1'b0;
        cap_valid = 1'b0;
        cap_perr = 1'b0;
        cap_ferr = 1'b0;
        cap_data = 8'h00;
        m_clear();
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_push_pop_full();
        test_rx_en();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..9.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 8: sample_tick pulses per bit, legal 8 or 16.
REQ-003 The block SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: FIFO entries, power of two, 2..64.
REQ-005 The block SHALL have port sys_clk, input, 1: the only clock (one clock; all logic on its rising edge).
REQ-006 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port sample_tick, input, 1: single-cycle enable at OVERSAMPLE x baud rate.
REQ-008 The block SHALL have port rx_data_in, input, 1: asynchronous serial line, idle high.
REQ-009 The block SHALL have port rx_en, input, 1: receiver enable.
REQ-010 The block SHALL have port rx_req, input, 1: pop request.
REQ-011 The block SHALL have port rx_data_out, output, DATA_BITS: popped data.
REQ-012 The block SHALL have port rx_valid, output, 1: rx_data_out/rx_perr/rx_ferr valid this cycle.
REQ-013 The block SHALL have port rx_perr, output, 1: parity error of the popped entry.
REQ-014 The block SHALL have port rx_ferr, output, 1: framing error of the popped entry.
REQ-015 The block SHALL have port rx_empty, output, 1: FIFO empty.
REQ-016 The block SHALL have port rx_full, output, 1: FIFO full.
REQ-017 The block SHALL have port rx_count, output, clog2(FIFO_DEPTH)+1: occupancy.
REQ-018 The block SHALL have port overrun, output, 1: sticky; a frame was dropped.
REQ-019 The block SHALL have port err_clr, input, 1: clears overrun.

Function
REQ-020 rx_data_in SHALL pass a 2-flop synchronizer before any use.
REQ-021 The FSM SHALL use states IDLE, START, DATA, PARITY, STOP; a per-bit tick counter 0..OVERSAMPLE-1 SHALL advance only on sample_tick.
REQ-022 IDLE->START SHALL occur on a sample_tick with rx_en=1 and the synchronized line low; the tick counter SHALL be cleared.
REQ-023 In START, at tick OVERSAMPLE/2, a high line SHALL return the FSM to IDLE (glitch rejected, nothing written); otherwise START SHALL end at tick OVERSAMPLE-1.
REQ-024 Each bit value SHALL be the 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; the bit SHALL complete at tick OVERSAMPLE-1.
REQ-025 DATA SHALL receive DATA_BITS bits, LSB first; PARITY SHALL be skipped when PARITY=0.
REQ-026 Parity error SHALL be set when the XOR of data and the parity bit is 1 (even) or 0 (odd).
REQ-027 STOP SHALL take one bit; stop bit 0 SHALL set the entry's framing error; the FSM SHALL return to IDLE at the STOP decision tick, not at the end of the stop bit.
REQ-028 At the STOP decision, {ferr, perr, data} SHALL be pushed in the same cycle; if the FIFO is full and no pop occurs that cycle, the frame SHALL be dropped and overrun set.
REQ-029 A pop SHALL occur when rx_req=1 and rx_empty=0; rx_data_out/rx_perr/rx_ferr SHALL be registered and rx_valid SHALL pulse exactly one cycle later.
REQ-030 rx_req while empty SHALL be ignored: no pop, rx_valid=0, and rx_data_out holds its value.
REQ-031 A push and a pop in the same cycle SHALL both succeed even when full, leaving rx_count unchanged.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; rx_count SHALL equal the entries held, and rx_full SHALL equal (rx_count==FIFO_DEPTH).
REQ-033 err_clr SHALL clear overrun; if err_clr and a new overrun coincide, overrun SHALL remain 1.
REQ-034 rx_en=0 SHALL not abort a frame in progress but SHALL block new START entry; pops SHALL be unaffected.

Reset
REQ-035 rst=1 SHALL, on the next sys_clk edge, force IDLE, clear counters and pointers, and set the synchronizer to 1.
REQ-036 Reset values SHALL be: rx_data_out=0, rx_valid=0, rx_perr=0, rx_ferr=0, rx_empty=1, rx_full=0, rx_count=0, overrun=0.
REQ-037 Reset mid-frame SHALL discard the partial frame and all FIFO contents.

Structure
REQ-038 The parity-mode encodings and state enumeration SHALL reside in the shared package uart_pkg.
REQ-039 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH); the receive FSM SHALL stay in uart_rx_fifo.

Verification
REQ-040 Check: DATA_BITS=8, PARITY=0, frame 0x55 sent, then rx_req -> rx_valid after 1 cycle, rx_data_out=0x55, perr=0, ferr=0.
REQ-041 Check: PARITY=1, frame 0xA3 sent with parity bit 1 -> rx_perr=1 on pop, data 0xA3.
REQ-042 Check: 0x0F sent with stop bit 0 -> rx_ferr=1; next frame 0x10 is received cleanly.
REQ-043 Check: low glitch of 2 ticks (OVERSAMPLE=8) -> FSM back to IDLE, rx_count stays 0.
REQ-044 Check: FIFO_DEPTH=4, 5 frames 0x01..0x05, no pops -> overrun=1, pops return 0x01..0x04, err_clr clears overrun.
REQ-045 Check: full FIFO with push and pop in the same cycle -> rx_count stays 4 and overrun stays 0; rst mid-frame -> all outputs at reset values.
